// File: rtl/wavetable_voice_scheduler.sv
// Shares the wavetable BRAM read port among NUM_VOICES voices and mixes their samples once per tick.
// Define MIX_SATURATE_EN for a saturating offset mix instead of the default averaging mix.
module wavetable_voice_scheduler #(
  parameter int NUM_VOICES   = 4,
  parameter int PHASE_WIDTH  = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              sample_tick_in,
  input  logic [NUM_VOICES-1:0]             voice_active_in,
  input  logic [NUM_VOICES*PHASE_WIDTH-1:0] phase_in,
  output logic [ADDR_WIDTH-1:0]             bram_addr_out,
  input  logic [DATA_WIDTH-1:0]             bram_data_in,
  output logic [DATA_WIDTH-1:0]             sample_out,
  output logic                              sample_valid_out,
  output logic                              busy_out,
  output logic                              overrun_out
);

  localparam int LOG2V = $clog2(NUM_VOICES);
  localparam int ACC_W = DATA_WIDTH + LOG2V + 1;
  localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
  localparam logic [BRAM_LATENCY-1:0] LAST_MASK = BRAM_LATENCY'(1) << (BRAM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                         state_q, state_d;
  logic [LOG2V-1:0]               idx_q, idx_d;
  logic [NUM_VOICES*ADDR_WIDTH-1:0] snapAddr_q, snapAddr_d;
  logic [NUM_VOICES-1:0]          snapActive_q, snapActive_d;
  logic [ADDR_WIDTH-1:0]          addr_q, addr_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic [BRAM_LATENCY-1:0]        tagValid_q, tagValid_d;
  logic [BRAM_LATENCY-1:0]        tagActive_q, tagActive_d;
  logic [DATA_WIDTH-1:0]          sample_q, sample_d;
  logic                           valid_q, valid_d;
  logic                           overrun_q, overrun_d;

  logic signed [ACC_W-1:0] dataExt, midExt, contrib, mixSum;
  logic [DATA_WIDTH-1:0]   mix;
  logic [LOG2V-1:0]        idxNext;
  logic                    unusedPhaseBits;

  assign unusedPhaseBits = ^phase_in;
  assign dataExt = ACC_W'(bram_data_in);
  assign midExt  = ACC_W'(MID);
  assign idxNext = idx_q + 1'b1;

  // Per-voice contribution and final mix arithmetic; mix is taken from the accumulator's next value
  // so the voice exiting the tag pipeline on the DRAIN->DONE edge is included.
  always_comb begin
    contrib = '0;
    mix     = '0;
    mixSum  = '0;
`ifdef MIX_SATURATE_EN
    if (tagActive_q[BRAM_LATENCY-1]) contrib = dataExt - midExt;
    mixSum = acc_d + midExt;
    if (mixSum < 0)
      mix = '0;
    else if (mixSum > ACC_W'({DATA_WIDTH{1'b1}}))
      mix = '1;
    else
      mix = mixSum[DATA_WIDTH-1:0];
`else
    contrib = tagActive_q[BRAM_LATENCY-1] ? dataExt : midExt;
    mix     = acc_d[LOG2V +: DATA_WIDTH];
`endif
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snapAddr_d   = snapAddr_q;
    snapActive_d = snapActive_q;
    addr_d       = addr_q;
    acc_d        = acc_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    overrun_d    = overrun_q;
    tagValid_d   = '0;
    tagActive_d  = '0;
    for (int k = 1; k < BRAM_LATENCY; k++) begin
      tagValid_d[k]  = tagValid_q[k-1];
      tagActive_d[k] = tagActive_q[k-1];
    end

    if (tagValid_q[BRAM_LATENCY-1]) acc_d = acc_q + contrib;
    if (sample_tick_in && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (sample_tick_in) begin
          for (int v = 0; v < NUM_VOICES; v++)
            snapAddr_d[v*ADDR_WIDTH +: ADDR_WIDTH] =
              phase_in[v*PHASE_WIDTH + PHASE_WIDTH - ADDR_WIDTH +: ADDR_WIDTH];
          snapActive_d = voice_active_in;
          addr_d       = phase_in[PHASE_WIDTH-1 -: ADDR_WIDTH];
          acc_d        = '0;
          idx_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        tagValid_d[0]  = 1'b1;
        tagActive_d[0] = snapActive_q[idx_q];
        if (idx_q == LOG2V'(NUM_VOICES - 1)) begin
          state_d = DRAIN;
        end else begin
          idx_d  = idxNext;
          addr_d = snapAddr_q[idxNext*ADDR_WIDTH +: ADDR_WIDTH];
        end
      end
      DRAIN: begin
        // Only the final stage may still hold a tag; it is accumulated on this same edge.
        if ((tagValid_q & ~LAST_MASK) == '0) begin
          sample_d = mix;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snapAddr_q   <= '0;
      snapActive_q <= '0;
      addr_q       <= '0;
      acc_q        <= '0;
      tagValid_q   <= '0;
      tagActive_q  <= '0;
      sample_q     <= MID;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snapAddr_q   <= snapAddr_d;
      snapActive_q <= snapActive_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      tagValid_q   <= tagValid_d;
      tagActive_q  <= tagActive_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bram_addr_out    = addr_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign busy_out         = (state_q != IDLE);
  assign overrun_out      = overrun_q;

endmodule

// File: tb/tb_wavetable_voice_scheduler.sv
// Self-checking bench for wavetable_voice_scheduler with a latency-2 BRAM model returning addr[7:0].
module tb_wavetable_voice_scheduler;
  localparam int NV = 4, PW = 32, AW = 16, DW = 8, LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             tick;
  logic [NV-1:0]    voiceActive;
  logic [NV*PW-1:0] phase;
  logic [AW-1:0]    bramAddr;
  logic [DW-1:0]    bramData;
  logic [DW-1:0]    sampleOut;
  logic             sampleValid;
  logic             busy;
  logic             overrun;

  wavetable_voice_scheduler #(
    .NUM_VOICES(NV), .PHASE_WIDTH(PW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BRAM_LATENCY(LAT)
  ) dut (
    .clk_in(clk), .rst_in(rst), .sample_tick_in(tick), .voice_active_in(voiceActive),
    .phase_in(phase), .bram_addr_out(bramAddr), .bram_data_in(bramData),
    .sample_out(sampleOut), .sample_valid_out(sampleValid), .busy_out(busy),
    .overrun_out(overrun)
  );

  // BRAM port-A model: data for an address appears two cycles later.
  logic [7:0] bramPipe1, bramPipe2;
  always @(posedge clk) begin
    bramPipe1 <= bramAddr[7:0];
    bramPipe2 <= bramPipe1;
  end
  assign bramData = bramPipe2;

  typedef struct {
    string            name;
    logic [3:0]       active;
    logic [3:0][7:0]  data;
    int               expAvg;
    int               expSat;
  } vec_t;

  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;
  int   expQ[$];

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic int pickExp(input vec_t v);
`ifdef MIX_SATURATE_EN
    return v.expSat;
`else
    return v.expAvg;
`endif
  endfunction

  // Drives one tick at the current negedge (cycle T) and follows the mix; overrunAt injects a
  // second tick at T+overrunAt, resetAt3 pulses reset at T+3 and returns at the negedge of T+6.
  task automatic applyStimulus(input vec_t v, input int overrunAt, input bit resetAt3,
                               input int expOverrun);
    int pulses;
    int pulseCycle;
    int nCycles;
    int expSample;
    pulses     = 0;
    pulseCycle = -1;
    nCycles    = resetAt3 ? 6 : 10;
    expSample  = pickExp(v);
    for (int i = 0; i < NV; i++)
      phase[i*PW +: PW] = {8'h00, v.data[i], 16'($urandom)};
    voiceActive = v.active;
    tick        = 1'b1;
    if (!resetAt3) expQ.push_back(expSample);
    for (int k = 1; k <= nCycles; k++) begin
      @(negedge clk);
      if (k == 1) tick = 1'b0;
      if (k == 2) phase = ~phase;
      if (overrunAt != 0 && k == overrunAt) tick = 1'b1;
      if (overrunAt != 0 && k == overrunAt + 1) tick = 1'b0;
      if (resetAt3 && k == 3) rst = 1'b1;
      if (resetAt3 && k == 4) rst = 1'b0;
      if (!resetAt3 && k <= NV)
        checkOutput($sformatf("%s addr v%0d", v.name, k - 1), int'(bramAddr),
                    int'({8'h00, v.data[k-1]}));
      checkOutput($sformatf("%s busy T+%0d", v.name, k), int'(busy),
                  resetAt3 ? int'(k <= 3) : int'(k <= 7));
      if (resetAt3 && k >= 4)
        checkOutput($sformatf("%s sample after reset T+%0d", v.name, k), int'(sampleOut), 128);
      if (sampleValid) begin
        pulses++;
        pulseCycle = k;
        if (expQ.size() > 0)
          checkOutput($sformatf("%s sample", v.name), int'(sampleOut), expQ.pop_front());
        else
          checkOutput($sformatf("%s unexpected pulse queue", v.name), expQ.size(), 1);
      end
    end
    if (resetAt3) begin
      checkOutput($sformatf("%s pulses", v.name), pulses, 0);
    end else begin
      checkOutput($sformatf("%s pulses", v.name), pulses, 1);
      checkOutput($sformatf("%s pulse cycle", v.name), pulseCycle, 7);
      checkOutput($sformatf("%s overrun", v.name), int'(overrun), expOverrun);
    end
  endtask

  initial begin
    vecs[0] = '{"chord",      4'b1111, {8'd160, 8'd140, 8'd120, 8'd100}, 130, 136};
    vecs[1] = '{"voice0",     4'b0001, {8'd250, 8'd99,  8'd17,  8'd200}, 146, 200};
    vecs[2] = '{"full250",    4'b1111, {8'd250, 8'd250, 8'd250, 8'd250}, 250, 255};
    vecs[3] = '{"allzero",    4'b1111, {8'd0,   8'd0,   8'd0,   8'd0},   0,   0};
    vecs[4] = '{"silent",     4'b0000, {8'd80,  8'd70,  8'd60,  8'd50},  128, 128};
    vecs[5] = '{"voices1_3",  4'b1010, {8'd90,  8'd30,  8'd200, 8'd10},  136, 162};

    rst         = 1'b1;
    tick        = 1'b0;
    voiceActive = '0;
    phase       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset sample", int'(sampleOut), 128);
    checkOutput("reset valid", int'(sampleValid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset addr", int'(bramAddr), 0);
    @(negedge clk);
    checkOutput("idle busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 0, 1'b0, 0);

    $display("[TB] overrun tick at T+3");
    applyStimulus(vecs[0], 3, 1'b0, 1);
    applyStimulus(vecs[1], 0, 1'b0, 1);

    $display("[TB] reset pulse at T+3, new tick at T+6");
    applyStimulus(vecs[2], 0, 1'b1, 0);
    applyStimulus(vecs[0], 0, 1'b0, 0);

    $display("[TB] tick during DONE");
    applyStimulus(vecs[5], 7, 1'b0, 1);

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
